// File: rtl/apb2axi_bridge.sv
// APB slave to single-beat AXI4 master bridge.
// Each APB access becomes one AXI transaction; PREADY waits for the AXI response.
module apb2axi_bridge #(
    parameter int APB_ADDR_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ID_WIDTH   = 6,
    parameter int AXI_USER_WIDTH = 6,
    parameter int AXI_ID         = 0
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [APB_ADDR_WIDTH-1:0]   paddr_i,
    input  logic                        pwrite_i,
    input  logic                        psel_i,
    input  logic                        penable_i,
    input  logic [31:0]                 pwdata_i,
    output logic [31:0]                 prdata_o,
    output logic                        pready_o,
    output logic                        pslverr_o,
    output logic                        aw_valid_o,
    input  logic                        aw_ready_i,
    output logic [AXI_ADDR_WIDTH-1:0]   aw_addr_o,
    output logic [AXI_ID_WIDTH-1:0]     aw_id_o,
    output logic [7:0]                  aw_len_o,
    output logic [2:0]                  aw_size_o,
    output logic [1:0]                  aw_burst_o,
    output logic                        aw_lock_o,
    output logic [3:0]                  aw_cache_o,
    output logic [2:0]                  aw_prot_o,
    output logic [3:0]                  aw_qos_o,
    output logic [3:0]                  aw_region_o,
    output logic [AXI_USER_WIDTH-1:0]   aw_user_o,
    output logic                        w_valid_o,
    input  logic                        w_ready_i,
    output logic [AXI_DATA_WIDTH-1:0]   w_data_o,
    output logic [AXI_DATA_WIDTH/8-1:0] w_strb_o,
    output logic                        w_last_o,
    output logic [AXI_USER_WIDTH-1:0]   w_user_o,
    input  logic                        b_valid_i,
    output logic                        b_ready_o,
    input  logic [1:0]                  b_resp_i,
    input  logic [AXI_ID_WIDTH-1:0]     b_id_i,
    input  logic [AXI_USER_WIDTH-1:0]   b_user_i,
    output logic                        ar_valid_o,
    input  logic                        ar_ready_i,
    output logic [AXI_ADDR_WIDTH-1:0]   ar_addr_o,
    output logic [AXI_ID_WIDTH-1:0]     ar_id_o,
    output logic [7:0]                  ar_len_o,
    output logic [2:0]                  ar_size_o,
    output logic [1:0]                  ar_burst_o,
    output logic                        ar_lock_o,
    output logic [3:0]                  ar_cache_o,
    output logic [2:0]                  ar_prot_o,
    output logic [3:0]                  ar_qos_o,
    output logic [3:0]                  ar_region_o,
    output logic [AXI_USER_WIDTH-1:0]   ar_user_o,
    input  logic                        r_valid_i,
    output logic                        r_ready_o,
    input  logic [1:0]                  r_resp_i,
    input  logic [AXI_DATA_WIDTH-1:0]   r_data_i,
    input  logic                        r_last_i,
    input  logic [AXI_ID_WIDTH-1:0]     r_id_i,
    input  logic [AXI_USER_WIDTH-1:0]   r_user_i
);

    typedef enum logic [2:0] {
        IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE
    } state_t;

    state_t                    state_q, state_d;
    logic [APB_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]               wdata_q, wdata_d;
    logic [31:0]               prdata_q, prdata_d;
    logic                      aw_done_q, aw_done_d;
    logic                      w_done_q, w_done_d;
    logic                      err_q, err_d;
    logic [31:0]               r_lane;
    logic [AXI_ADDR_WIDTH-1:0] addr_ext;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            prdata_q  <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            prdata_q  <= prdata_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        prdata_d  = prdata_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        err_d     = err_q;
        unique case (state_q)
            IDLE: begin
                if (psel_i & penable_i & !pready_o) begin
                    addr_d    = paddr_i;
                    wdata_d   = pwdata_i;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = pwrite_i ? WR_REQ : RD_REQ;
                end
            end
            WR_REQ: begin
                // AW and W complete independently, in any order
                aw_done_d = aw_done_q | aw_ready_i;
                w_done_d  = w_done_q | w_ready_i;
                if (aw_done_d & w_done_d) state_d = WR_RESP;
            end
            WR_RESP: begin
                if (b_valid_i) begin
                    err_d   = b_resp_i[1];
                    state_d = DONE;
                end
            end
            RD_REQ: begin
                if (ar_ready_i) state_d = RD_RESP;
            end
            RD_RESP: begin
                if (r_valid_i) begin
                    prdata_d = r_lane;
                    err_d    = r_resp_i[1];
                    state_d  = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        aw_valid_o = 1'b0;
        w_valid_o  = 1'b0;
        b_ready_o  = 1'b0;
        ar_valid_o = 1'b0;
        r_ready_o  = 1'b0;
        pready_o   = 1'b0;
        pslverr_o  = 1'b0;
        unique case (state_q)
            WR_REQ: begin
                aw_valid_o = !aw_done_q;
                w_valid_o  = !w_done_q;
            end
            WR_RESP: b_ready_o  = 1'b1;
            RD_REQ:  ar_valid_o = 1'b1;
            RD_RESP: r_ready_o  = 1'b1;
            DONE: begin
                pready_o  = 1'b1;
                pslverr_o = err_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        addr_ext = '0;
        addr_ext[APB_ADDR_WIDTH-1:2] = addr_q[APB_ADDR_WIDTH-1:2];
    end

    // Narrow APB data rides on the 32-bit lane picked by addr[2]
    if (AXI_DATA_WIDTH == 64) begin : g_dw64
        assign w_data_o = {wdata_q, wdata_q};
        assign w_strb_o = addr_q[2] ? 8'hF0 : 8'h0F;
        assign r_lane   = addr_q[2] ? r_data_i[63:32] : r_data_i[31:0];
    end else begin : g_dw32
        assign w_data_o = wdata_q;
        assign w_strb_o = '1;
        assign r_lane   = r_data_i[31:0];
    end

    assign prdata_o    = prdata_q;
    assign aw_addr_o   = addr_ext;
    assign ar_addr_o   = addr_ext;
    assign aw_id_o     = AXI_ID_WIDTH'(AXI_ID);
    assign ar_id_o     = AXI_ID_WIDTH'(AXI_ID);
    assign aw_len_o    = 8'd0;
    assign ar_len_o    = 8'd0;
    assign aw_size_o   = 3'b010;
    assign ar_size_o   = 3'b010;
    assign aw_burst_o  = 2'b01;
    assign ar_burst_o  = 2'b01;
    assign aw_lock_o   = 1'b0;
    assign ar_lock_o   = 1'b0;
    assign aw_cache_o  = 4'd0;
    assign ar_cache_o  = 4'd0;
    assign aw_prot_o   = 3'd0;
    assign ar_prot_o   = 3'd0;
    assign aw_qos_o    = 4'd0;
    assign ar_qos_o    = 4'd0;
    assign aw_region_o = 4'd0;
    assign ar_region_o = 4'd0;
    assign aw_user_o   = '0;
    assign ar_user_o   = '0;
    assign w_user_o    = '0;
    assign w_last_o    = 1'b1;

    logic unused_ok;
    assign unused_ok = ^{b_id_i, b_user_i, b_resp_i[0], r_last_i, r_id_i,
                         r_user_i, r_resp_i[0], addr_q[1:0]};

endmodule

// File: tb/tb_apb2axi_bridge.sv
// Directed bench for apb2axi_bridge: 32-bit and 64-bit instances
// share the AXI stimulus; psel picks which one is addressed.
module tb_apb2axi_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] paddr = '0, pwdata = '0;
    logic        pwrite = 1'b0, penable = 1'b0;
    logic        psel32 = 1'b0, psel64 = 1'b0;
    logic        aw_ready = 1'b0, w_ready = 1'b0, ar_ready = 1'b0;
    logic        b_valid = 1'b0, r_valid = 1'b0, r_last = 1'b1;
    logic [1:0]  b_resp = '0, r_resp = '0;
    logic [63:0] r_data = '0;
    logic [5:0]  b_id = '0, b_user = '0, r_id = '0, r_user = '0;
    logic        use64 = 1'b0;

    always #5 clk = ~clk;

    // 32-bit instance outputs
    logic [31:0] prdata_a, awaddr_a, araddr_a, wdata_a;
    logic        pready_a, pslverr_a, awv_a, wv_a, bready_a, arv_a, rready_a;
    logic [5:0]  awid_a, arid_a, awuser_a, aruser_a, wuser_a;
    logic [7:0]  awlen_a, arlen_a;
    logic [2:0]  awsize_a, arsize_a, awprot_a, arprot_a;
    logic [1:0]  awburst_a, arburst_a;
    logic        awlock_a, arlock_a, wlast_a;
    logic [3:0]  awcache_a, arcache_a, awqos_a, arqos_a;
    logic [3:0]  awreg_a, arreg_a, wstrb_a;

    // 64-bit instance outputs
    logic [31:0] prdata_b, awaddr_b, araddr_b;
    logic [63:0] wdata_b;
    logic        pready_b, pslverr_b, awv_b, wv_b, bready_b, arv_b, rready_b;
    logic [5:0]  awid_b, arid_b, awuser_b, aruser_b, wuser_b;
    logic [7:0]  awlen_b, arlen_b, wstrb_b;
    logic [2:0]  awsize_b, arsize_b, awprot_b, arprot_b;
    logic [1:0]  awburst_b, arburst_b;
    logic        awlock_b, arlock_b, wlast_b;
    logic [3:0]  awcache_b, arcache_b, awqos_b, arqos_b, awreg_b, arreg_b;

    apb2axi_bridge #(.AXI_DATA_WIDTH(32)) dut32 (
        .clk_i(clk), .rst_i(rst), .paddr_i(paddr), .pwrite_i(pwrite),
        .psel_i(psel32), .penable_i(penable), .pwdata_i(pwdata),
        .prdata_o(prdata_a), .pready_o(pready_a), .pslverr_o(pslverr_a),
        .aw_valid_o(awv_a), .aw_ready_i(aw_ready), .aw_addr_o(awaddr_a),
        .aw_id_o(awid_a), .aw_len_o(awlen_a), .aw_size_o(awsize_a),
        .aw_burst_o(awburst_a), .aw_lock_o(awlock_a), .aw_cache_o(awcache_a),
        .aw_prot_o(awprot_a), .aw_qos_o(awqos_a), .aw_region_o(awreg_a),
        .aw_user_o(awuser_a), .w_valid_o(wv_a), .w_ready_i(w_ready),
        .w_data_o(wdata_a), .w_strb_o(wstrb_a), .w_last_o(wlast_a),
        .w_user_o(wuser_a), .b_valid_i(b_valid), .b_ready_o(bready_a),
        .b_resp_i(b_resp), .b_id_i(b_id), .b_user_i(b_user),
        .ar_valid_o(arv_a), .ar_ready_i(ar_ready), .ar_addr_o(araddr_a),
        .ar_id_o(arid_a), .ar_len_o(arlen_a), .ar_size_o(arsize_a),
        .ar_burst_o(arburst_a), .ar_lock_o(arlock_a), .ar_cache_o(arcache_a),
        .ar_prot_o(arprot_a), .ar_qos_o(arqos_a), .ar_region_o(arreg_a),
        .ar_user_o(aruser_a), .r_valid_i(r_valid), .r_ready_o(rready_a),
        .r_resp_i(r_resp), .r_data_i(r_data[31:0]), .r_last_i(r_last),
        .r_id_i(r_id), .r_user_i(r_user)
    );

    apb2axi_bridge #(.AXI_DATA_WIDTH(64)) dut64 (
        .clk_i(clk), .rst_i(rst), .paddr_i(paddr), .pwrite_i(pwrite),
        .psel_i(psel64), .penable_i(penable), .pwdata_i(pwdata),
        .prdata_o(prdata_b), .pready_o(pready_b), .pslverr_o(pslverr_b),
        .aw_valid_o(awv_b), .aw_ready_i(aw_ready), .aw_addr_o(awaddr_b),
        .aw_id_o(awid_b), .aw_len_o(awlen_b), .aw_size_o(awsize_b),
        .aw_burst_o(awburst_b), .aw_lock_o(awlock_b), .aw_cache_o(awcache_b),
        .aw_prot_o(awprot_b), .aw_qos_o(awqos_b), .aw_region_o(awreg_b),
        .aw_user_o(awuser_b), .w_valid_o(wv_b), .w_ready_i(w_ready),
        .w_data_o(wdata_b), .w_strb_o(wstrb_b), .w_last_o(wlast_b),
        .w_user_o(wuser_b), .b_valid_i(b_valid), .b_ready_o(bready_b),
        .b_resp_i(b_resp), .b_id_i(b_id), .b_user_i(b_user),
        .ar_valid_o(arv_b), .ar_ready_i(ar_ready), .ar_addr_o(araddr_b),
        .ar_id_o(arid_b), .ar_len_o(arlen_b), .ar_size_o(arsize_b),
        .ar_burst_o(arburst_b), .ar_lock_o(arlock_b), .ar_cache_o(arcache_b),
        .ar_prot_o(arprot_b), .ar_qos_o(arqos_b), .ar_region_o(arreg_b),
        .ar_user_o(aruser_b), .r_valid_i(r_valid), .r_ready_o(rready_b),
        .r_resp_i(r_resp), .r_data_i(r_data), .r_last_i(r_last),
        .r_id_i(r_id), .r_user_i(r_user)
    );

    // View of whichever instance is currently addressed
    logic        s_pready, s_pslverr, s_awv, s_wv, s_bready, s_arv, s_rready;
    logic [31:0] s_prdata, s_awaddr, s_araddr;
    logic [63:0] s_wdata;
    logic [7:0]  s_wstrb;
    assign s_pready  = use64 ? pready_b  : pready_a;
    assign s_pslverr = use64 ? pslverr_b : pslverr_a;
    assign s_awv     = use64 ? awv_b     : awv_a;
    assign s_wv      = use64 ? wv_b      : wv_a;
    assign s_bready  = use64 ? bready_b  : bready_a;
    assign s_arv     = use64 ? arv_b     : arv_a;
    assign s_rready  = use64 ? rready_b  : rready_a;
    assign s_prdata  = use64 ? prdata_b  : prdata_a;
    assign s_awaddr  = use64 ? awaddr_b  : awaddr_a;
    assign s_araddr  = use64 ? araddr_b  : araddr_a;
    assign s_wdata   = use64 ? wdata_b   : {32'h0, wdata_a};
    assign s_wstrb   = use64 ? wstrb_b   : {4'h0, wstrb_a};

    typedef struct {
        logic        dw64;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [63:0] rdata;
        logic [1:0]  resp;
        int          aw_dly;
        int          w_dly;
        int          ar_dly;
        int          rsp_dly;
        logic [31:0] e_addr;
        logic [63:0] e_wdata;
        logic [7:0]  e_strb;
        logic [31:0] e_prdata;
        logic        e_err;
        int          e_lat;
    } vec_t;

    int total = 0;
    int bad = 0;
    logic [31:0] exp_prd32 = '0;
    logic [31:0] exp_prd64 = '0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run(input vec_t t);
        int  awc, wc, arc, rw;
        bit  done;
        awc = 0; wc = 0; arc = 0; rw = 0; done = 0;
        @(negedge clk);
        use64 = t.dw64;
        psel32 = !t.dw64;
        psel64 = t.dw64;
        penable = 1'b0;
        paddr = t.addr;
        pwrite = t.wr;
        pwdata = t.wdata;
        r_data = t.rdata;
        b_resp = t.resp;
        r_resp = t.resp;
        aw_ready = 1'b0; w_ready = 1'b0; ar_ready = 1'b0;
        b_valid = 1'b0; r_valid = 1'b0;
        @(negedge clk);
        penable = 1'b1;
        for (int k = 1; k <= 40 && !done; k++) begin
            @(negedge clk);
            if (s_bready) chk("bready_early", 64'(awc == 1 && wc == 1), 64'd1);
            aw_ready = (k >= 1 + t.aw_dly);
            w_ready  = (k >= 1 + t.w_dly);
            ar_ready = (k >= 1 + t.ar_dly);
            if (s_awv) begin
                chk("aw_addr", 64'(s_awaddr), 64'(t.e_addr));
                if (aw_ready) awc++;
            end
            if (s_wv) begin
                chk("w_data", s_wdata, t.e_wdata);
                chk("w_strb", 64'(s_wstrb), 64'(t.e_strb));
                if (w_ready) wc++;
            end
            if (s_arv) begin
                chk("ar_addr", 64'(s_araddr), 64'(t.e_addr));
                if (ar_ready) arc++;
            end
            if (s_bready) begin b_valid = (rw >= t.rsp_dly); rw++; end
            else b_valid = 1'b0;
            if (s_rready) begin r_valid = (rw >= t.rsp_dly); rw++; end
            else r_valid = 1'b0;
            if (s_pready) begin
                done = 1;
                chk("latency", 64'(k), 64'(t.e_lat));
                chk("pslverr", 64'(s_pslverr), 64'(t.e_err));
                chk("aw_beats", 64'(awc), t.wr ? 64'd1 : 64'd0);
                chk("w_beats", 64'(wc), t.wr ? 64'd1 : 64'd0);
                chk("ar_beats", 64'(arc), t.wr ? 64'd0 : 64'd1);
                if (!t.wr) begin
                    if (t.dw64) exp_prd64 = t.e_prdata;
                    else exp_prd32 = t.e_prdata;
                end
                chk("prdata", 64'(s_prdata), t.dw64 ? 64'(exp_prd64)
                                                    : 64'(exp_prd32));
                psel32 = 1'b0; psel64 = 1'b0; penable = 1'b0;
            end
        end
        chk("no_timeout", 64'(done), 64'd1);
        psel32 = 1'b0; psel64 = 1'b0; penable = 1'b0;
        b_valid = 1'b0; r_valid = 1'b0;
        @(negedge clk);
        chk("pready_pulse", 64'(s_pready), 64'd0);
    endtask

    vec_t v[12];
    vec_t rv;

    initial begin
        v[0]  = '{1'b0, 1'b1, 32'h1000_0004, 32'hDEAD_BEEF, 64'h0, 2'b00,
                  0, 0, 0, 0, 32'h1000_0004, 64'hDEAD_BEEF, 8'h0F, 32'h0, 1'b0, 3};
        v[1]  = '{1'b0, 1'b0, 32'h2000_0000, 32'h0, 64'h1234_5678, 2'b00,
                  0, 0, 5, 0, 32'h2000_0000, 64'h0, 8'h00, 32'h1234_5678, 1'b0, 8};
        v[2]  = '{1'b0, 1'b1, 32'h3000_0008, 32'h0BAD_F00D, 64'h0, 2'b00,
                  3, 1, 0, 0, 32'h3000_0008, 64'h0BAD_F00D, 8'h0F, 32'h0, 1'b0, 6};
        v[3]  = '{1'b0, 1'b1, 32'h4000_0010, 32'h0102_0304, 64'h0, 2'b10,
                  0, 0, 0, 0, 32'h4000_0010, 64'h0102_0304, 8'h0F, 32'h0, 1'b1, 3};
        v[4]  = '{1'b0, 1'b0, 32'h4000_0014, 32'h0, 64'hCAFE_F00D, 2'b11,
                  0, 0, 0, 0, 32'h4000_0014, 64'h0, 8'h00, 32'hCAFE_F00D, 1'b1, 3};
        v[5]  = '{1'b0, 1'b0, 32'h4000_0018, 32'h0, 64'h8765_4321, 2'b01,
                  0, 0, 0, 2, 32'h4000_0018, 64'h0, 8'h00, 32'h8765_4321, 1'b0, 5};
        v[6]  = '{1'b0, 1'b1, 32'h4000_001C, 32'hA5A5_A5A5, 64'h0, 2'b01,
                  2, 0, 0, 1, 32'h4000_001C, 64'hA5A5_A5A5, 8'h0F, 32'h0, 1'b0, 6};
        v[7]  = '{1'b0, 1'b1, 32'h5000_0007, 32'h1357_9BDF, 64'h0, 2'b00,
                  0, 2, 0, 0, 32'h5000_0004, 64'h1357_9BDF, 8'h0F, 32'h0, 1'b0, 5};
        v[8]  = '{1'b1, 1'b1, 32'h6000_0004, 32'h1122_3344, 64'h0, 2'b00,
                  0, 0, 0, 0, 32'h6000_0004, 64'h1122_3344_1122_3344, 8'hF0,
                  32'h0, 1'b0, 3};
        v[9]  = '{1'b1, 1'b0, 32'h6000_0004, 32'h0, 64'hAAAA_BBBB_CCCC_DDDD,
                  2'b00, 0, 0, 0, 0, 32'h6000_0004, 64'h0, 8'h00,
                  32'hAAAA_BBBB, 1'b0, 3};
        v[10] = '{1'b1, 1'b0, 32'h6000_0000, 32'h0, 64'hAAAA_BBBB_CCCC_DDDD,
                  2'b00, 0, 0, 1, 0, 32'h6000_0000, 64'h0, 8'h00,
                  32'hCCCC_DDDD, 1'b0, 4};
        v[11] = '{1'b1, 1'b1, 32'h6000_000B, 32'h5A5A_0F0F, 64'h0, 2'b10,
                  1, 1, 0, 0, 32'h6000_0008, 64'h5A5A_0F0F_5A5A_0F0F, 8'h0F,
                  32'h0, 1'b1, 4};
        rv    = '{1'b0, 1'b0, 32'h7000_0000, 32'h0, 64'h55AA_55AA, 2'b00,
                  0, 0, 0, 0, 32'h7000_0000, 64'h0, 8'h00, 32'h55AA_55AA, 1'b0, 3};

        // Reset values and constant side-band
        @(negedge clk);
        chk("rst_pready", 64'({pready_a, pready_b}), 64'd0);
        chk("rst_pslverr", 64'({pslverr_a, pslverr_b}), 64'd0);
        chk("rst_prdata", {prdata_a, prdata_b}, 64'd0);
        chk("rst_valids", 64'({awv_a, wv_a, arv_a, awv_b, wv_b, arv_b}), 64'd0);
        chk("rst_readys", 64'({bready_a, rready_a, bready_b, rready_b}), 64'd0);
        chk("aw_len", 64'({awlen_a, arlen_b}), 64'd0);
        chk("ar_size", 64'({arsize_a, awsize_b}), 64'({3'b010, 3'b010}));
        chk("burst", 64'({awburst_a, arburst_b}), 64'({2'b01, 2'b01}));
        chk("w_last", 64'({wlast_a, wlast_b}), 64'd3);
        chk("ids", 64'({awid_a, arid_b}), 64'd0);
        chk("cache_prot", 64'({awcache_a, arprot_b, awlock_b, awqos_a}), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Setup phase alone must not start a transfer
        psel32 = 1'b1;
        penable = 1'b0;
        pwrite = 1'b1;
        repeat (3) @(negedge clk);
        chk("setup_ignored", 64'({awv_a, wv_a, arv_a, pready_a}), 64'd0);
        psel32 = 1'b0;

        for (int i = 0; i < 12; i++) run(v[i]);

        // Reset while both write valids are up
        @(negedge clk);
        use64 = 1'b0;
        psel32 = 1'b1;
        pwrite = 1'b1;
        paddr = 32'h1000_0000;
        pwdata = 32'h0000_0001;
        aw_ready = 1'b0; w_ready = 1'b0;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        psel32 = 1'b0;
        penable = 1'b0;
        chk("wrreq_valids", 64'({awv_a, wv_a}), 64'd3);
        rst = 1'b1;
        #1;
        chk("rst_drop_valids", 64'({awv_a, wv_a}), 64'd0);
        chk("rst_prdata_mid", 64'(prdata_a), 64'd0);
        exp_prd32 = '0;
        exp_prd64 = '0;
        @(negedge clk);
        rst = 1'b0;
        chk("post_rst_idle", 64'({awv_a, wv_a, bready_a, pready_a}), 64'd0);
        run(rv);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
